ysyx_22051013_mem_arbiter: RTL and testbench

//  Shares the core's single 64-bit memory port between the instruction fetch unit (IF) and the LSU (MEM).

---
 rtl/ysyx_22051013_mem_arbiter_pkg.sv | 25 ++
 rtl/ysyx_22051013_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_22051013_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_mem_arbiter_pkg.sv
// Shared encodings for the IF/LSU memory-port arbiter.
package ysyx_22051013_mem_arbiter_pkg;

  // Transaction FSM: choose a requester, present it on the bus, await the response.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Which requester owns the transaction currently on the bus.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // MEM grants tolerated while IF waits before IF is forced to the front.
  localparam int STARVE_N_DEFAULT = 2;

  // Pick the 32-bit instruction out of a 64-bit beat using address bit 2.
  function automatic logic [31:0] select_word(input logic hi, input logic [63:0] data);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22051013_mem_arbiter.sv
// Shares the single 64-bit memory port between instruction fetch and the LSU.
// One transaction in flight; MEM has priority, an aging counter keeps IF from
// starving, and a redirect kill swallows the response of a stale fetch.
module ysyx_22051013_mem_arbiter
  import ysyx_22051013_mem_arbiter_pkg::*;
#(
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int STARVE_N = STARVE_N_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [7:0]    mem_wmask,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  output logic          bus_valid,
  input  logic          bus_ready,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [7:0]    bus_wmask,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  localparam int CW = $clog2(STARVE_N + 1);

  state_e          state_reg, state_next;
  owner_e          owner_reg, owner_next;
  logic            drop_reg, drop_next;
  logic [CW-1:0]   starve_reg, starve_next;
  logic            we_reg, we_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   wdata_reg, wdata_next;
  logic [7:0]      wmask_reg, wmask_next;
  logic            if_gnt_reg, if_gnt_next;
  logic            mem_gnt_reg, mem_gnt_next;
  logic            if_rvalid_reg, if_rvalid_next;
  logic            mem_rvalid_reg, mem_rvalid_next;
  logic [31:0]     if_rdata_reg, if_rdata_next;
  logic [DW-1:0]   mem_rdata_reg, mem_rdata_next;

  logic            if_take;
  logic            starve_full;
  logic            sel_if;
  logic            sel_mem;
  logic            owner_is_if;

  // A fetch raised together with a kill is already stale, so it is not eligible.
  assign if_take     = if_req && !if_kill;
  assign starve_full = (starve_reg == CW'(STARVE_N));
  assign sel_if      = if_take && (starve_full || !mem_req);
  assign sel_mem     = mem_req && !sel_if;
  assign owner_is_if = (owner_reg == OWN_IF);

  assign bus_valid  = (state_reg == S_REQ);
  assign bus_we     = we_reg;
  assign bus_addr   = addr_reg;
  assign bus_wdata  = wdata_reg;
  assign bus_wmask  = wmask_reg;
  assign if_gnt     = if_gnt_reg;
  assign mem_gnt    = mem_gnt_reg;
  assign if_rvalid  = if_rvalid_reg;
  assign mem_rvalid = mem_rvalid_reg;
  assign if_rdata   = if_rdata_reg;
  assign mem_rdata  = mem_rdata_reg;

  // Next-state, request latching, starvation aging and response routing.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    drop_next       = drop_reg;
    starve_next     = starve_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wmask_next      = wmask_reg;
    if_gnt_next     = 1'b0;
    mem_gnt_next    = 1'b0;
    if_rvalid_next  = 1'b0;
    mem_rvalid_next = 1'b0;
    if_rdata_next   = if_rdata_reg;
    mem_rdata_next  = mem_rdata_reg;

    case (state_reg)
      S_IDLE: begin
        drop_next = 1'b0;
        if (sel_if) begin
          owner_next = OWN_IF;
          we_next    = 1'b0;
          addr_next  = if_addr;
          wdata_next = '0;
          wmask_next = '0;
          state_next = S_REQ;
        end else if (sel_mem) begin
          owner_next = OWN_MEM;
          we_next    = mem_we;
          addr_next  = mem_addr;
          wdata_next = mem_wdata;
          wmask_next = mem_wmask;
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        // The request stays on the bus even if the fetch is killed; only the reply is dropped.
        if (owner_is_if && if_kill) begin
          drop_next = 1'b1;
        end
        if (bus_ready) begin
          state_next = S_WAIT;
          if (owner_is_if) begin
            if_gnt_next = 1'b1;
            starve_next = '0;
          end else begin
            mem_gnt_next = 1'b1;
            if (if_req && !starve_full) begin
              starve_next = starve_reg + CW'(1);
            end
          end
        end
      end

      S_WAIT: begin
        if (owner_is_if && if_kill) begin
          drop_next = 1'b1;
        end
        if (bus_rvalid) begin
          state_next = S_IDLE;
          drop_next  = 1'b0;
          if (owner_is_if) begin
            // A kill landing on the response cycle still counts as a redirect.
            if (!(drop_reg || if_kill)) begin
              if_rvalid_next = 1'b1;
              if_rdata_next  = select_word(addr_reg[2], 64'(bus_rdata));
            end
          end else begin
            mem_rvalid_next = 1'b1;
            mem_rdata_next  = bus_rdata;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      owner_reg      <= OWN_IF;
      drop_reg       <= 1'b0;
      starve_reg     <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
      if_gnt_reg     <= 1'b0;
      mem_gnt_reg    <= 1'b0;
      if_rvalid_reg  <= 1'b0;
      mem_rvalid_reg <= 1'b0;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      drop_reg       <= drop_next;
      starve_reg     <= starve_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wmask_reg      <= wmask_next;
      if_gnt_reg     <= if_gnt_next;
      mem_gnt_reg    <= mem_gnt_next;
      if_rvalid_reg  <= if_rvalid_next;
      mem_rvalid_reg <= mem_rvalid_next;
      if_rdata_reg   <= if_rdata_next;
      mem_rdata_reg  <= mem_rdata_next;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// Directed bench for the IF/LSU memory arbiter with a scripted bus responder
// and scoreboard queues of expected read returns.
module tb_ysyx_22051013_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_kill;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  ysyx_22051013_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] if_exp[$];
  logic [63:0] mem_exp[$];
  bit          gnt_log[$];     // 1 = MEM grant, 0 = IF grant
  int          if_todo, mem_todo;
  int          ready_hold, resp_lat, ready_cnt, rsp_wait;
  bit          rsp_pend, acc;
  logic [63:0] acc_addr, rsp_data;
  int          cyc;
  int          if_pulses, mem_pulses, if_gnts, mem_gnts;
  int          last_if_gnt_cyc, last_mem_rv_cyc;
  int          p0, m0, g0;
  logic [5:0]  order;

  // Memory contents seen by the bus responder.
  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a[63:3] == 61'h1000_0000) return 64'h0010_0093_0000_0013;
    return {a[31:0] ^ 32'hdead_beef, a[31:0] ^ 32'h1234_5678};
  endfunction

  function automatic logic [31:0] insn_of(input logic [63:0] a);
    logic [63:0] d;
    d = mem_fn(a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observe DUT outputs for the current cycle and pop the scoreboard on returns.
  task automatic monitor();
    if (if_gnt) begin
      if_gnts++;
      last_if_gnt_cyc = cyc;
      gnt_log.push_back(1'b0);
    end
    if (mem_gnt) begin
      mem_gnts++;
      gnt_log.push_back(1'b1);
    end
    if (if_rvalid) begin
      if_pulses++;
      chk("if_rvalid_expected", 64'(if_exp.size() != 0), 64'd1);
      if (if_exp.size() != 0) chk("if_rdata", 64'(if_rdata), 64'(if_exp.pop_front()));
    end
    if (mem_rvalid) begin
      mem_pulses++;
      last_mem_rv_cyc = cyc;
      chk("mem_rvalid_expected", 64'(mem_exp.size() != 0), 64'd1);
      if (mem_exp.size() != 0) chk("mem_rdata", mem_rdata, mem_exp.pop_front());
    end
  endtask

  // Bus responder: optional ready stall, then a response resp_lat cycles after accept.
  task automatic bus_drive();
    if (acc) begin
      rsp_pend = 1'b1;
      rsp_wait = resp_lat;
      rsp_data = mem_fn(acc_addr);
    end
    bus_rvalid = 1'b0;
    bus_rdata  = 64'hbad0_bad0_bad0_bad0;
    if (rsp_pend) begin
      if (rsp_wait == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rsp_data;
        rsp_pend   = 1'b0;
      end else begin
        rsp_wait--;
      end
    end
    if (bus_valid) begin
      if (ready_cnt < ready_hold) begin
        bus_ready = 1'b0;
        ready_cnt++;
      end else begin
        bus_ready = 1'b1;
      end
    end else begin
      ready_cnt = 0;
      bus_ready = (ready_hold == 0);
    end
  endtask

  // Requesters hold their level until granted; expectations are recorded at grant.
  task automatic requesters();
    if (if_req && if_gnt) begin
      if_exp.push_back(insn_of(if_addr));
      if_todo--;
      if (if_todo > 0) if_addr = if_addr + 64'd4;
      else if_req = 1'b0;
    end
    if (mem_req && mem_gnt) begin
      mem_exp.push_back(mem_fn(mem_addr));
      mem_todo--;
      if (mem_todo > 0) mem_addr = mem_addr + 64'd8;
      else mem_req = 1'b0;
    end
  endtask

  task automatic step();
    acc      = bus_valid && bus_ready;
    acc_addr = bus_addr;
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    bus_drive();
    requesters();
  endtask

  task automatic issue_if(input logic [63:0] a, input int n);
    if_addr = a;
    if_todo = n;
    if_req  = 1'b1;
  endtask

  task automatic issue_mem(input logic [63:0] a, input int n, input logic we,
                           input logic [63:0] wd, input logic [7:0] wm);
    mem_addr  = a;
    mem_todo  = n;
    mem_we    = we;
    mem_wdata = wd;
    mem_wmask = wm;
    mem_req   = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((if_todo > 0 || mem_todo > 0 || rsp_pend || bus_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_bound", 64'(n < budget), 64'd1);
    step();
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({bus_valid, bus_we, if_gnt, if_rvalid, mem_gnt, mem_rvalid}), 64'd0);
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 64'd0);
    chk({tag, "_bus_addr"}, bus_addr, 64'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 64'd0);
    chk({tag, "_bus_wmask"}, 64'(bus_wmask), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    if_todo = 0; mem_todo = 0; ready_hold = 0; resp_lat = 0; ready_cnt = 0;
    rsp_wait = 0; rsp_pend = 1'b0; cyc = 0;
    if_pulses = 0; mem_pulses = 0; if_gnts = 0; mem_gnts = 0;
    last_if_gnt_cyc = 0; last_mem_rv_cyc = 0;

    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: single fetch, minimum latency, upper word selected by addr[2]
    issue_if(64'h0000_0000_8000_0004, 1);
    step();
    chk("t1_bus_valid", 64'(bus_valid), 64'd1);
    chk("t1_bus_addr", bus_addr, 64'h0000_0000_8000_0004);
    chk("t1_bus_we", 64'(bus_we), 64'd0);
    chk("t1_gnt_early", 64'(if_gnt), 64'd0);
    step();
    chk("t1_if_gnt", 64'(if_gnt), 64'd1);
    step();
    chk("t1_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t1_if_rdata", 64'(if_rdata), 64'h0010_0093);
    step();
    chk("t1_rvalid_pulse", 64'(if_rvalid), 64'd0);

    // 2: simultaneous requests, MEM first, IF granted right after MEM returns
    gnt_log.delete();
    issue_mem(64'h0000_0000_8000_1000, 1, 1'b0, 64'd0, 8'h00);
    issue_if(64'h0000_0000_8000_0100, 1);
    drain(50);
    chk("t2_grant_count", 64'(gnt_log.size()), 64'd2);
    chk("t2_first_mem", 64'(gnt_log.size() > 0 && gnt_log[0]), 64'd1);
    chk("t2_if_after_mem", 64'(last_if_gnt_cyc - last_mem_rv_cyc), 64'd2);

    // 3: MEM held continuously, IF waiting: aging forces IF every third grant
    gnt_log.delete();
    issue_mem(64'h0000_0000_8000_2000, 4, 1'b0, 64'd0, 8'h00);
    issue_if(64'h0000_0000_8000_0200, 2);
    drain(100);
    chk("t3_grant_count", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) order = {order[4:0], (i < gnt_log.size()) ? gnt_log[i] : 1'b0};
    chk("t3_grant_order", 64'(order), 64'b110110);

    // 4: kill during WAIT with a slow response: reply consumed, no if_rvalid
    resp_lat = 4;
    p0 = if_pulses;
    issue_if(64'h0000_0000_8000_0010, 1);
    step();
    step();
    chk("t4_if_gnt", 64'(if_gnt), 64'd1);
    step();
    if_kill = 1'b1;
    void'(if_exp.pop_back());
    step();
    if_kill = 1'b0;
    chk("t4_no_new_bus", 64'(bus_valid), 64'd0);
    for (int i = 0; i < 5; i++) step();
    chk("t4_no_if_rvalid", 64'(if_pulses - p0), 64'd0);
    resp_lat = 0;
    issue_if(64'h0000_0000_8000_0018, 1);
    drain(50);
    chk("t4_next_fetch", 64'(if_pulses - p0), 64'd1);

    // 4b: kill in the same cycle as bus_rvalid drops the reply
    resp_lat = 1;
    p0 = if_pulses;
    issue_if(64'h0000_0000_8000_0040, 1);
    step();
    step();
    step();
    chk("t4b_bus_rvalid", 64'(bus_rvalid), 64'd1);
    if_kill = 1'b1;
    void'(if_exp.pop_back());
    step();
    if_kill = 1'b0;
    chk("t4b_if_rvalid", 64'(if_rvalid), 64'd0);
    step();
    chk("t4b_no_pulse", 64'(if_pulses - p0), 64'd0);
    resp_lat = 0;

    // 4c: kill together with a new fetch request does not start it that cycle
    issue_if(64'h0000_0000_8000_0044, 1);
    if_kill = 1'b1;
    step();
    chk("t4c_no_start", 64'(bus_valid), 64'd0);
    if_kill = 1'b0;
    step();
    chk("t4c_starts", 64'(bus_valid), 64'd1);
    chk("t4c_addr", bus_addr, 64'h0000_0000_8000_0044);
    drain(50);

    // 5: store stalled by bus_ready=0 for 5 cycles: request held stable, single gnt
    ready_hold = 5;
    g0 = mem_gnts;
    issue_mem(64'h0000_0000_8000_2008, 1, 1'b1, 64'h0123_4567_89ab_cdef, 8'h0f);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_valid_held", 64'({bus_valid, bus_ready, mem_gnt}), 64'b100);
      chk("t5_addr_held", bus_addr, 64'h0000_0000_8000_2008);
      chk("t5_wdata_held", bus_wdata, 64'h0123_4567_89ab_cdef);
      chk("t5_we_wmask", 64'({bus_we, bus_wmask}), 64'h10f);
    end
    step();
    chk("t5_ready_cycle", 64'({bus_valid, bus_ready, mem_gnt}), 64'b110);
    step();
    chk("t5_mem_gnt", 64'(mem_gnt), 64'd1);
    ready_hold = 0;
    drain(50);
    chk("t5_single_gnt", 64'(mem_gnts - g0), 64'd1);

    // 6: reset in WAIT, response arrives afterwards and is ignored
    resp_lat = 2;
    p0 = if_pulses;
    issue_if(64'h0000_0000_8000_0030, 1);
    step();
    step();
    chk("t6_if_gnt", 64'(if_gnt), 64'd1);
    rst = 1'b1;
    void'(if_exp.pop_back());
    step();
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    step();
    chk("t6_late_rvalid", 64'(bus_rvalid), 64'd1);
    step();
    chk("t6_no_rvalid", 64'({if_rvalid, mem_rvalid, bus_valid}), 64'd0);
    chk("t6_no_pulse", 64'(if_pulses - p0), 64'd0);
    resp_lat = 0;

    // 7: kill while MEM owns the bus is ignored
    m0 = mem_pulses;
    issue_mem(64'h0000_0000_8000_3000, 1, 1'b0, 64'd0, 8'h00);
    step();
    step();
    if_kill = 1'b1;
    step();
    if_kill = 1'b0;
    chk("t7_mem_rvalid", 64'(mem_rvalid), 64'd1);
    drain(50);
    chk("t7_mem_count", 64'(mem_pulses - m0), 64'd1);

    // Post-reset fetch still works and every expectation was consumed
    issue_if(64'h0000_0000_8000_0038, 1);
    drain(50);
    chk("sb_if_empty", 64'(if_exp.size()), 64'd0);
    chk("sb_mem_empty", 64'(mem_exp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
